// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants plus the bank and reader state encodings used
// by the layer-2 flattener.
package cnn_pkg;

    localparam int FEAT_W      = 8;
    localparam int L2_OUT_CH   = 16;
    localparam int L2_POOL_PIX = 16;
    localparam int L2_FLAT_LEN = L2_OUT_CH * L2_POOL_PIX;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/flat_bank_mem.sv
// One image bank: NUM_PIX words, each holding all channels of a pooled pixel.
// A full-width write port and a registered single-feature read port.
module flat_bank_mem
    import cnn_pkg::*;
#(
    parameter int DATA_W  = FEAT_W,
    parameter int NUM_PIX = L2_POOL_PIX,
    parameter int NUM_CH  = L2_OUT_CH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [$clog2(NUM_PIX)-1:0] i_wr_pix,
    input  logic [NUM_CH*DATA_W-1:0]   i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(NUM_PIX)-1:0] i_rd_pix,
    input  logic [$clog2(NUM_CH)-1:0]  i_rd_ch,
    output logic [DATA_W-1:0]          o_rd_data
);

    logic [NUM_CH*DATA_W-1:0] r_mem [NUM_PIX];
    logic [DATA_W-1:0]        r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_pix] <= i_wr_data;
        end
    end

    // Read register holds its value when not enabled, so a stalled beat stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_pix][i_rd_ch*DATA_W +: DATA_W];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/layer2_feature_flattener.sv
// Captures 16 pooled pixels x 16 channels into ping-pong banks and replays each
// image as a flat valid/ready feature stream for the fully-connected stage.
module layer2_feature_flattener
    import cnn_pkg::*;
#(
    parameter int DATA_W   = FEAT_W,
    parameter int NUM_PIX  = L2_POOL_PIX,
    parameter bit CH_MAJOR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ch0,
    input  logic [DATA_W-1:0] in_ch1,
    input  logic [DATA_W-1:0] in_ch2,
    input  logic [DATA_W-1:0] in_ch3,
    input  logic [DATA_W-1:0] in_ch4,
    input  logic [DATA_W-1:0] in_ch5,
    input  logic [DATA_W-1:0] in_ch6,
    input  logic [DATA_W-1:0] in_ch7,
    input  logic [DATA_W-1:0] in_ch8,
    input  logic [DATA_W-1:0] in_ch9,
    input  logic [DATA_W-1:0] in_ch10,
    input  logic [DATA_W-1:0] in_ch11,
    input  logic [DATA_W-1:0] in_ch12,
    input  logic [DATA_W-1:0] in_ch13,
    input  logic [DATA_W-1:0] in_ch14,
    input  logic [DATA_W-1:0] in_ch15,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_index,
    output logic              out_last,
    output logic              frame_done,
    output logic              overflow
);

    localparam int NUM_CH = L2_OUT_CH;
    localparam int PIX_W  = $clog2(NUM_PIX);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = PIX_W + CH_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L2_FLAT_LEN - 1);

    bank_state_t        r_bank_state [2];
    logic               r_wr_bank;
    logic [PIX_W-1:0]   r_wr_pix;
    logic               r_rd_bank;
    rd_state_t          r_rd_state;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic               r_out_bank;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_frame_done;
    logic               r_overflow;

    logic [NUM_CH*DATA_W-1:0] w_wr_data;
    logic                     w_wr_accept;
    logic                     w_beat_accept;
    logic                     w_other_bank;
    logic                     w_other_full;
    logic                     w_rd_en;
    logic                     w_rd_sel;
    logic [CNT_W-1:0]         w_rd_cnt;
    logic [PIX_W-1:0]         w_rd_pix;
    logic [CH_W-1:0]          w_rd_ch;
    logic [DATA_W-1:0]        w_bank_rd_data [2];

    assign w_wr_data = {in_ch15, in_ch14, in_ch13, in_ch12, in_ch11, in_ch10, in_ch9, in_ch8,
                        in_ch7,  in_ch6,  in_ch5,  in_ch4,  in_ch3,  in_ch2,  in_ch1, in_ch0};

    assign w_wr_accept   = in_valid && (r_bank_state[r_wr_bank] == BANK_EMPTY ||
                                        r_bank_state[r_wr_bank] == BANK_FILLING);
    assign w_beat_accept = r_out_valid && out_ready;
    assign w_other_bank  = ~r_rd_bank;
    assign w_other_full  = (r_bank_state[w_other_bank] == BANK_FULL);

    // Address of the beat that will be on the output after this edge.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_sel = r_rd_bank;
        w_rd_cnt = '0;
        if (r_rd_state == RD_IDLE) begin
            w_rd_en = (r_bank_state[r_rd_bank] == BANK_FULL);
        end else if (w_beat_accept) begin
            if (r_rd_cnt == LAST_CNT) begin
                w_rd_en  = w_other_full;
                w_rd_sel = w_other_bank;
            end else begin
                w_rd_en  = 1'b1;
                w_rd_cnt = r_rd_cnt + CNT_W'(1);
            end
        end
    end

    generate
        if (CH_MAJOR) begin : g_ch_major
            assign w_rd_ch  = w_rd_cnt[CNT_W-1 -: CH_W];
            assign w_rd_pix = w_rd_cnt[PIX_W-1:0];
        end else begin : g_pix_major
            assign w_rd_pix = w_rd_cnt[CNT_W-1 -: PIX_W];
            assign w_rd_ch  = w_rd_cnt[CH_W-1:0];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            flat_bank_mem #(
                .DATA_W  (DATA_W),
                .NUM_PIX (NUM_PIX),
                .NUM_CH  (NUM_CH)
            ) u_mem (
                .clk       (clk),
                .rst       (rst),
                .i_wr_en   (w_wr_accept && (r_wr_bank == 1'(gi))),
                .i_wr_pix  (r_wr_pix),
                .i_wr_data (w_wr_data),
                .i_rd_en   (w_rd_en && (w_rd_sel == 1'(gi))),
                .i_rd_pix  (w_rd_pix),
                .i_rd_ch   (w_rd_ch),
                .o_rd_data (w_bank_rd_data[gi])
            );
        end
    endgenerate

    // Writer only touches EMPTY/FILLING banks, reader only FULL/DRAINING ones,
    // so their bank-state updates never collide on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_state[0] <= BANK_EMPTY;
            r_bank_state[1] <= BANK_EMPTY;
            r_wr_bank       <= 1'b0;
            r_wr_pix        <= '0;
            r_rd_bank       <= 1'b0;
            r_rd_state      <= RD_IDLE;
            r_rd_cnt        <= '0;
            r_out_bank      <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_wr_accept) begin
                if (r_wr_pix == PIX_W'(NUM_PIX - 1)) begin
                    r_bank_state[r_wr_bank] <= BANK_FULL;
                    r_wr_pix                <= '0;
                    r_wr_bank               <= ~r_wr_bank;
                end else begin
                    r_bank_state[r_wr_bank] <= BANK_FILLING;
                    r_wr_pix                <= r_wr_pix + PIX_W'(1);
                end
            end else if (in_valid) begin
                r_overflow <= 1'b1;
            end

            if (w_rd_en) begin
                r_rd_cnt   <= w_rd_cnt;
                r_out_last <= (w_rd_cnt == LAST_CNT);
                r_out_bank <= w_rd_sel;
            end

            case (r_rd_state)
                RD_IDLE: begin
                    if (r_bank_state[r_rd_bank] == BANK_FULL) begin
                        r_rd_state              <= RD_DRAIN;
                        r_bank_state[r_rd_bank] <= BANK_DRAINING;
                        r_out_valid             <= 1'b1;
                    end
                end
                RD_DRAIN: begin
                    if (w_beat_accept && r_rd_cnt == LAST_CNT) begin
                        r_bank_state[r_rd_bank] <= BANK_EMPTY;
                        r_rd_bank               <= w_other_bank;
                        r_frame_done            <= 1'b1;
                        if (w_other_full) begin
                            r_bank_state[w_other_bank] <= BANK_DRAINING;
                        end else begin
                            r_rd_state  <= RD_IDLE;
                            r_out_valid <= 1'b0;
                            r_rd_cnt    <= '0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = w_bank_rd_data[r_out_bank];
    assign out_index  = 8'(r_rd_cnt);
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_layer2_feature_flattener.sv
// Bench for layer2_feature_flattener: a channel-major and a pixel-major instance
// share stimulus; a scoreboard queue feeds a monitor checking both outputs.
module tb_layer2_feature_flattener;

    typedef struct {
        logic [7:0] d1;   // expected data, channel-major instance
        logic [7:0] d0;   // expected data, pixel-major instance
        logic [7:0] idx;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] tb_ch [16];

    logic       o_valid [2];
    logic [7:0] o_data  [2];
    logic [7:0] o_index [2];
    logic       o_last  [2];
    logic       o_fd    [2];
    logic       o_ov    [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q [$];
    logic [7:0] img [16][16];

    int   ready_mode  = 0;   // 0 always, 1 random 30%, 2 never, 3 random 50%
    int   bubble_left = 0;

    always #5 clk = ~clk;

    layer2_feature_flattener #(.DATA_W(8), .NUM_PIX(16), .CH_MAJOR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ch0(tb_ch[0]),   .in_ch1(tb_ch[1]),   .in_ch2(tb_ch[2]),   .in_ch3(tb_ch[3]),
        .in_ch4(tb_ch[4]),   .in_ch5(tb_ch[5]),   .in_ch6(tb_ch[6]),   .in_ch7(tb_ch[7]),
        .in_ch8(tb_ch[8]),   .in_ch9(tb_ch[9]),   .in_ch10(tb_ch[10]), .in_ch11(tb_ch[11]),
        .in_ch12(tb_ch[12]), .in_ch13(tb_ch[13]), .in_ch14(tb_ch[14]), .in_ch15(tb_ch[15]),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]),
        .out_index(o_index[1]), .out_last(o_last[1]), .frame_done(o_fd[1]), .overflow(o_ov[1])
    );

    layer2_feature_flattener #(.DATA_W(8), .NUM_PIX(16), .CH_MAJOR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ch0(tb_ch[0]),   .in_ch1(tb_ch[1]),   .in_ch2(tb_ch[2]),   .in_ch3(tb_ch[3]),
        .in_ch4(tb_ch[4]),   .in_ch5(tb_ch[5]),   .in_ch6(tb_ch[6]),   .in_ch7(tb_ch[7]),
        .in_ch8(tb_ch[8]),   .in_ch9(tb_ch[9]),   .in_ch10(tb_ch[10]), .in_ch11(tb_ch[11]),
        .in_ch12(tb_ch[12]), .in_ch13(tb_ch[13]), .in_ch14(tb_ch[14]), .in_ch15(tb_ch[15]),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]),
        .out_index(o_index[0]), .out_last(o_last[0]), .frame_done(o_fd[0]), .overflow(o_ov[0])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready changes just after the rising edge so the monitor's falling-edge
    // view is the value used at the next rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 99) < 30);
                3:       out_ready = ($urandom_range(0, 99) < 50);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    int         cyc = 0;
    bit         prev_stall = 0;
    bit         prev_last_acc = 0;
    bit         pend_bubble = 0;
    int         last_acc_cyc = 0;
    logic [7:0] prev_d [2];
    logic [7:0] prev_i [2];
    exp_t       mon_e;
    bit         mon_hs;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall    = 0;
            prev_last_acc = 0;
            pend_bubble   = 0;
        end else begin
            check("lockstep_valid", o_valid[0], o_valid[1]);
            for (int d = 0; d < 2; d++) begin
                if (prev_last_acc || o_fd[d])
                    check($sformatf("frame_done_dut%0d", d), o_fd[d], prev_last_acc);
                if (prev_stall)
                    check($sformatf("stall_stable_dut%0d", d),
                          {o_valid[d], o_data[d], o_index[d]}, {1'b1, prev_d[d], prev_i[d]});
            end
            mon_hs = o_valid[1] && out_ready;
            prev_last_acc = 0;
            if (mon_hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("data_chmaj_k%0d", mon_e.idx), o_data[1], mon_e.d1);
                    check($sformatf("data_pixmaj_k%0d", mon_e.idx), o_data[0], mon_e.d0);
                    check($sformatf("index_last_k%0d", mon_e.idx),
                          {o_index[1], o_last[1], o_index[0], o_last[0]},
                          {mon_e.idx, mon_e.last, mon_e.idx, mon_e.last});
                    if (mon_e.idx == 8'd0 && pend_bubble) begin
                        check("no_bubble_gap", cyc - last_acc_cyc, 1);
                        pend_bubble = 0;
                    end
                    if (mon_e.last) begin
                        last_acc_cyc  = cyc;
                        prev_last_acc = 1;
                        if (bubble_left > 0) begin
                            pend_bubble = 1;
                            bubble_left--;
                        end
                    end
                end
            end
            prev_stall = o_valid[1] && !out_ready;
            for (int d = 0; d < 2; d++) begin
                prev_d[d] = o_data[d];
                prev_i[d] = o_index[d];
            end
        end
    end

    // Reference model: pix = position in the 4x4 map, ch = channel.
    // Channel-major beat k reads (pix=k%16, ch=k/16); pixel-major reads (pix=k/16, ch=k%16).
    task automatic send_image(input bit accept);
        exp_t e;
        if (accept) begin
            for (int k = 0; k < 256; k++) begin
                e.d1   = img[k % 16][k / 16];
                e.d0   = img[k / 16][k % 16];
                e.idx  = 8'(k);
                e.last = (k == 255);
                exp_q.push_back(e);
            end
        end
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int c = 0; c < 16; c++) tb_ch[c] = img[p][c];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic ramp_image();
        for (int p = 0; p < 16; p++)
            for (int c = 0; c < 16; c++)
                img[p][c] = 8'(p * 16 + c - 128);
    endtask

    initial begin
        bit any_v;
        for (int c = 0; c < 16; c++) tb_ch[c] = 8'h00;

        // 1: reset mid-fill
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ramp_image();
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int c = 0; c < 16; c++) tb_ch[c] = img[p][c];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("reset_outputs_dut%0d", d),
                      {o_valid[d], o_data[d], o_index[d], o_last[d], o_fd[d], o_ov[d]}, 0);
        end
        rst = 1'b0;
        any_v = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_valid[0] || o_valid[1]) any_v = 1;
        end
        check("no_valid_after_reset", any_v, 0);

        // 2: single image, ready high, first-beat latency
        ready_mode = 0;
        ramp_image();
        send_image(1);
        check("valid_before_latency", o_valid[1], 0);
        @(negedge clk);
        check("first_valid_latency", o_valid[1], 1);
        wait_drain(2000);

        // 3: same image under 30% ready
        ready_mode = 1;
        ramp_image();
        send_image(1);
        wait_drain(6000);
        ready_mode = 0;

        // 4: ping-pong, image B captured while A drains
        bubble_left = 1;
        for (int p = 0; p < 16; p++) for (int c = 0; c < 16; c++) img[p][c] = 8'sd5;
        send_image(1);
        for (int p = 0; p < 16; p++) for (int c = 0; c < 16; c++) img[p][c] = 8'hFF;
        send_image(1);
        wait_drain(2000);

        // 7: two random images, 50% ready
        ready_mode = 3;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 16; p++) for (int c = 0; c < 16; c++) img[p][c] = 8'($urandom);
            send_image(1);
        end
        wait_drain(4000);
        ready_mode = 0;
        check("overflow_clear", {o_ov[1], o_ov[0]}, 0);

        // 5: overflow with consumer stalled
        ready_mode = 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 16; p++)
                for (int c = 0; c < 16; c++)
                    img[p][c] = 8'($urandom);
            send_image(i < 2);
        end
        repeat (5) @(negedge clk);
        check("overflow_set", {o_ov[1], o_ov[0]}, 2'b11);
        check("stalled_beat0", {o_valid[1], o_index[1]}, {1'b1, 8'd0});
        ready_mode = 0;
        wait_drain(2000);
        any_v = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_valid[0] || o_valid[1]) any_v = 1;
        end
        check("no_third_image", any_v, 0);
        check("overflow_sticky", {o_ov[1], o_ov[0]}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
